// File: rtl/carry_select_adder_pkg.sv
// Shared widths and operand type for the carry-select adder.
package carry_select_adder_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_BLOCK  = 4;
  localparam int NUM_BLOCKS = DEF_WIDTH / DEF_BLOCK;

  typedef logic [DEF_WIDTH-1:0] operand_t;

endpackage

// File: rtl/carry_select_adder_csa_ripple_block.sv
// BLOCK-bit ripple-carry adder; also exposes the carry into its MSB so the
// top block can feed the signed-overflow flag.
module csa_ripple_block #(
  parameter int BLOCK = 4
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             ci,
  output logic [BLOCK-1:0] s,
  output logic             co,
  output logic             c_msb
);

  logic c;

  always_comb begin
    s     = '0;
    c     = ci;
    c_msb = 1'b0;
    for (int i = 0; i < BLOCK; i++) begin
      if (i == BLOCK - 1) c_msb = c;
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    co = c;
  end

endmodule

// File: rtl/carry_select_adder.sv
// Registered carry-select adder: ripple low block, dual-precomputed upper
// blocks selected by the incoming block carry, one-cycle latency.
module carry_select_adder
  import carry_select_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int BLOCK = DEF_BLOCK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  // WIDTH must be a multiple of BLOCK and span at least two blocks.
  localparam int NB = WIDTH / BLOCK;

  logic [BLOCK-1:0] s_lo;
  logic             co_lo;
  logic             msb_lo;

  logic [BLOCK-1:0] s0   [1:NB-1];
  logic [BLOCK-1:0] s1   [1:NB-1];
  logic             co0  [1:NB-1];
  logic             co1  [1:NB-1];
  logic             msb0 [1:NB-1];
  logic             msb1 [1:NB-1];

  csa_ripple_block #(.BLOCK(BLOCK)) u_blk0 (
    .a     (a[BLOCK-1:0]),
    .b     (b[BLOCK-1:0]),
    .ci    (cin),
    .s     (s_lo),
    .co    (co_lo),
    .c_msb (msb_lo)
  );

  for (genvar k = 1; k < NB; k++) begin : g_blk
    csa_ripple_block #(.BLOCK(BLOCK)) u_ci0 (
      .a     (a[k*BLOCK +: BLOCK]),
      .b     (b[k*BLOCK +: BLOCK]),
      .ci    (1'b0),
      .s     (s0[k]),
      .co    (co0[k]),
      .c_msb (msb0[k])
    );
    csa_ripple_block #(.BLOCK(BLOCK)) u_ci1 (
      .a     (a[k*BLOCK +: BLOCK]),
      .b     (b[k*BLOCK +: BLOCK]),
      .ci    (1'b1),
      .s     (s1[k]),
      .co    (co1[k]),
      .c_msb (msb1[k])
    );
  end

  logic [WIDTH-1:0] core_sum;
  logic             core_c;
  logic             core_cmsb;

  // Select chain: each block's real carry-in picks the precomputed pair.
  always_comb begin
    core_sum            = '0;
    core_sum[BLOCK-1:0] = s_lo;
    core_c              = co_lo;
    core_cmsb           = msb_lo;
    for (int k = 1; k < NB; k++) begin
      core_sum[k*BLOCK +: BLOCK] = core_c ? s1[k] : s0[k];
      core_cmsb                  = core_c ? msb1[k] : msb0[k];
      core_c                     = core_c ? co1[k] : co0[k];
    end
  end

  logic             out_valid_d, out_valid_q;
  logic [WIDTH-1:0] result_d, result_q;
  logic             cout_d, cout_q;
  logic             overflow_d, overflow_q;

  always_comb begin
    out_valid_d = in_valid;
    result_d    = result_q;
    cout_d      = cout_q;
    overflow_d  = overflow_q;
    if (in_valid) begin
      result_d   = core_sum;
      cout_d     = core_c;
      overflow_d = core_c ^ core_cmsb;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      cout_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      cout_q      <= cout_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign cout      = cout_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_carry_select_adder.sv
// Self-checking bench for carry_select_adder: directed vector table, reset and
// handshake sequences, then randomized traffic against an arithmetic model.
module tb_carry_select_adder;
  import carry_select_adder_pkg::*;

  logic     clk = 1'b0;
  logic     rst = 1'b1;
  logic     in_valid = 1'b0;
  operand_t a = '0;
  operand_t b = '0;
  logic     cin = 1'b0;
  logic     out_valid;
  operand_t result;
  logic     cout;
  logic     overflow;

  int n_cmp = 0;
  int n_err = 0;

  carry_select_adder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .result    (result),
    .cout      (cout),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    string    name;
    operand_t a;
    operand_t b;
    logic     cin;
    operand_t r;
    logic     c;
    logic     o;
  } vec_t;

  vec_t vecs [$];

  function automatic void model(input operand_t x, input operand_t y, input logic ci,
                                output operand_t r, output logic c, output logic o);
    longint unsigned total;
    longint sx, sy, ss;
    total = longint'(x) + longint'(y) + longint'(ci);
    r = operand_t'(total);
    c = total >= 64'h1_0000_0000;
    // Signed overflow: the exact signed sum falls outside the 32-bit range.
    sx = longint'(signed'(x));
    sy = longint'(signed'(y));
    ss = sx + sy + longint'(ci);
    o = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
  endfunction

  task automatic check(input string name, input logic v, input operand_t r,
                       input logic c, input logic o);
    n_cmp++;
    if (out_valid !== v || result !== r || cout !== c || overflow !== o) begin
      n_err++;
      $display("FAIL %s: got v=%0b r=%h c=%0b o=%0b, want v=%0b r=%h c=%0b o=%0b",
               name, out_valid, result, cout, overflow, v, r, c, o);
    end
  endtask

  task automatic drive(input logic v, input operand_t x, input operand_t y, input logic ci);
    @(negedge clk);
    in_valid = v;
    a        = x;
    b        = y;
    cin      = ci;
  endtask

  operand_t last_r;
  logic     last_c, last_o;
  operand_t er;
  logic     ec, eo;

  initial begin
    vecs.push_back('{"pos_ovf",   32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b1});
    vecs.push_back('{"neg_ovf",   32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1});
    vecs.push_back('{"mixed",     32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h7FFFFFFE, 1'b1, 1'b0});
    vecs.push_back('{"negneg",    32'hFFFFFF00, 32'hFFFFFFFF, 1'b0, 32'hFFFFFEFF, 1'b1, 1'b0});
    vecs.push_back('{"cin_blk_a", 32'hF000FEFA, 32'h0000007B, 1'b1, 32'hF000FF76, 1'b0, 1'b0});
    vecs.push_back('{"cin_blk_b", 32'hF000000A, 32'h000000FF, 1'b1, 32'hF000010A, 1'b0, 1'b0});
    vecs.push_back('{"cin_blk_c", 32'h0F0A000A, 32'h000D00FF, 1'b1, 32'h0F17010A, 1'b0, 1'b0});
    vecs.push_back('{"full_rip",  32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0});
    vecs.push_back('{"ones_cin",  32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0});
    vecs.push_back('{"zero",      32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0});
    vecs.push_back('{"min_min",   32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1});
    vecs.push_back('{"pos_cin",   32'h7FFFFFFF, 32'h00000000, 1'b1, 32'h80000000, 1'b0, 1'b1});

    #12;
    check("reset_state", 1'b0, '0, 1'b0, 1'b0);
    drive(1'b1, 32'h12345678, 32'h11111111, 1'b0);
    @(posedge clk); #1;
    check("held_in_reset", 1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back: in_valid stays high across the whole table.
    foreach (vecs[i]) begin
      drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].cin);
      @(posedge clk); #1;
      check(vecs[i].name, 1'b1, vecs[i].r, vecs[i].c, vecs[i].o);
    end

    // Idle cycle drops out_valid and holds the last sum.
    drive(1'b0, 32'hDEADBEEF, 32'h0BADF00D, 1'b1);
    @(posedge clk); #1;
    check("idle_hold", 1'b0, vecs[vecs.size()-1].r, vecs[vecs.size()-1].c, vecs[vecs.size()-1].o);
    @(posedge clk); #1;
    check("idle_hold2", 1'b0, vecs[vecs.size()-1].r, vecs[vecs.size()-1].c, vecs[vecs.size()-1].o);

    // Asynchronous reset mid-stream, away from any clock edge.
    drive(1'b1, 32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0);
    @(posedge clk); #1;
    check("pre_reset", 1'b1, 32'hFFFFFFFE, 1'b0, 1'b1);
    drive(1'b1, 32'h00000001, 32'h00000002, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("async_reset", 1'b0, '0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("reset_discard", 1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("first_after_rel", 1'b1, 32'h00000003, 1'b0, 1'b0);

    // Randomized traffic, ~75% valid, against the arithmetic model.
    last_r = 32'h00000003; last_c = 1'b0; last_o = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      logic     v;
      operand_t x, y;
      logic     ci;
      v  = ($urandom_range(0, 3) != 0);
      x  = $urandom();
      y  = $urandom();
      ci = $urandom_range(0, 1);
      if ($urandom_range(0, 15) == 0) x = 32'hFFFFFFFF;
      if ($urandom_range(0, 15) == 0) y = ~x;
      drive(v, x, y, ci);
      @(posedge clk); #1;
      if (v) begin
        model(x, y, ci, er, ec, eo);
        last_r = er; last_c = ec; last_o = eo;
      end
      check("random", v, last_r, last_c, last_o);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/carry_select_adder.md
Name: carry_select_adder

Overview:
- 32-bit (parameterizable) two's-complement adder with carry-in, built as a carry-select structure.
- The word is split into fixed-width blocks. Each block above the lowest precomputes sums for carry-in 0 and carry-in 1, and the real block carry selects between them through a mux.
- Result, carry-out and signed-overflow flag are registered: one-cycle latency.
- Used as the datapath adder in ALU/MAC paths; it replaces a ripple adder where timing matters.

Parameters:
- WIDTH, 32, operand/result width in bits. Must be a multiple of BLOCK.
- BLOCK, 4, bits per carry-select block. The lowest block is a plain ripple block.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  qualifies a, b, cin this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- out_valid  output  1  result/cout/overflow hold a new sum.
- result  output  WIDTH  registered sum (a + b + cin) mod 2^WIDTH.
- cout  output  1  registered unsigned carry-out of the MSB.
- overflow  output  1  registered signed overflow flag.

Behaviour:
- Reset (rst=1, asynchronous, any time): result=0, cout=0, overflow=0, out_valid=0.
  - Held while rst is high. The first capture happens on the first rising clk after release.
  - Reset mid-operation discards any sample in flight.
- Combinational core:
  - Block 0 ripples from cin.
  - Block k>0 computes sum0/carry0 with carry-in 0 and sum1/carry1 with carry-in 1, in parallel.
  - Block k selects {sum, carry} = c_in_k ? {sum1, carry1} : {sum0, carry0}, where c_in_k is the selected carry-out of block k-1.
- Arithmetic rules:
  - {cout, result} = a + b + cin, computed at WIDTH+1 bits, all unsigned.
  - overflow = carry into MSB XOR carry out of MSB. Equivalently: (a[MSB]==b[MSB]) and (result[MSB]!=a[MSB]).
  - cin participates in both cout and overflow.
- Timing: on a rising clk with in_valid=1, capture the core outputs into result/cout/overflow and set out_valid=1.
  - Latency is exactly 1 cycle; throughput is 1 operation per cycle.
  - Back-to-back valid inputs produce back-to-back outputs.
- Idle: on a rising clk with in_valid=0, set out_valid=0. result/cout/overflow hold their previous values.
- No backpressure. Output is always accepted.
- Boundary cases:
  - a=b=all-ones with cin=1 gives result all-ones, cout=1, overflow=0.
  - Carries may ripple the full width through every select stage. Functional result must equal the plain adder for all inputs.

Decomposition:
- Shared package: WIDTH and BLOCK defaults and a derived constant NUM_BLOCKS = WIDTH/BLOCK. No typedefs needed beyond a WIDTH-bit operand type.
- One sub-module, csa_ripple_block: BLOCK-bit ripple-carry adder with inputs a, b, ci and outputs s, co, plus carry-into-MSB for the top block.
  - Instantiated once for block 0.
  - Instantiated twice per upper block (ci tied to 0 and to 1).
- Top level contains the generate loop, the select muxes, the overflow logic and the output registers.

Test Plan:
- Positive overflow: a=7FFFFFFF, b=7FFFFFFF, cin=0 -> result=FFFFFFFE, cout=0, overflow=1, one cycle after in_valid.
- Negative overflow: a=80000000, b=FFFFFFFF, cin=0 -> result=7FFFFFFF, cout=1, overflow=1.
- Mixed signs and negatives:
  - a=7FFFFFFF, b=FFFFFFFF, cin=0 -> 7FFFFFFE, cout=1, overflow=0.
  - a=FFFFFF00, b=FFFFFFFF, cin=0 -> FFFFFEFF, cout=1, overflow=0.
- Carry-in and block-boundary carries:
  - a=F000FEFA, b=0000007B, cin=1 -> F000FF76, cout=0, overflow=0.
  - a=F000000A, b=000000FF, cin=1 -> F000010A, 0, 0.
  - a=0F0A000A, b=000D00FF, cin=1 -> 0F17010A, 0, 0.
- Reset and handshake: assert rst mid-stream -> outputs 0 and out_valid=0 immediately, without waiting for clk.
  - After release, back-to-back valid inputs give results on consecutive cycles.
  - in_valid=0 drops out_valid and holds the last result.
- Random plus full ripple: a=FFFFFFFF, b=00000000, cin=1 -> result=0, cout=1, overflow=0.
  - Then 10k random vectors checked against a behavioural 33-bit sum and the overflow formula.
